// File: rtl/fir_input_stage.sv
// fir_input_stage: synchronizes pad-side strobed words into FIR samples or coefficient writes.
//   in : clk, reset (sync, active-high), pin_data/pin_valid/pin_set_coeffs (async pads), fir_ready
//   out: x_n + s_axis_fir_tvalid (sample handshake), coeff_wr_en/coeff_addr/coeff_data (tap writes),
//        load_done (full load finished, still in load mode), overrun (sticky dropped sample)
module fir_input_stage #(
  parameter int DATA_W   = 8,
  parameter int NUM_TAPS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pin_data,
  input  logic              pin_valid,
  input  logic              pin_set_coeffs,
  input  logic              fir_ready,
  output logic [DATA_W-1:0] x_n,
  output logic              s_axis_fir_tvalid,
  output logic              coeff_wr_en,
  output logic [3:0]        coeff_addr,
  output logic [DATA_W-1:0] coeff_data,
  output logic              load_done,
  output logic              overrun
);
  typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;
  state_t            state_q, state_d;
  logic [2:0]        vld_sync_q, vld_sync_d;
  logic [1:0]        set_sync_q, set_sync_d;
  logic [DATA_W-1:0] dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic [3:0]        cnt_q, cnt_d, addr_q, addr_d;
  logic [DATA_W-1:0] x_q, x_d, cdata_q, cdata_d;
  logic              tvalid_q, tvalid_d, wr_q, wr_d, done_q, done_d, ovr_q, ovr_d;
  logic              strobe, set_mode;
  always_comb begin
    vld_sync_d = {vld_sync_q[1:0], pin_valid};
    set_sync_d = {set_sync_q[0], pin_set_coeffs};
    dat_s1_d   = pin_data;
    dat_s2_d   = dat_s1_q;
    strobe     = vld_sync_q[1] & ~vld_sync_q[2];
    set_mode   = set_sync_q[1];
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    // a pending sample survives mode changes; it only clears on transfer
    tvalid_d   = tvalid_q & ~fir_ready;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    cdata_d    = cdata_q;
    ovr_d      = ovr_q;
    case (state_q)
      RUN: begin
        if (set_mode) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
        // a transfer in the same cycle frees the slot, so the new word loads without a bubble
        if (strobe) begin
          if (!tvalid_q || fir_ready) begin
            x_d      = dat_s2_q;
            tvalid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (!set_mode) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (strobe) begin
          wr_d    = 1'b1;
          addr_d  = cnt_q;
          cdata_d = dat_s2_q;
          cnt_d   = cnt_q + 4'd1;
          state_d = (cnt_q == 4'(NUM_TAPS - 1)) ? DONE : LOAD;
        end
      end
      DONE: begin
        if (!set_mode) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: state_d = RUN;
    endcase
    done_d = (state_d == DONE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      vld_sync_q <= '0;
      set_sync_q <= '0;
      dat_s1_q   <= '0;
      dat_s2_q   <= '0;
      cnt_q      <= '0;
      x_q        <= '0;
      tvalid_q   <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      cdata_q    <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vld_sync_q <= vld_sync_d;
      set_sync_q <= set_sync_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      tvalid_q   <= tvalid_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      cdata_q    <= cdata_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end
  assign x_n               = x_q;
  assign s_axis_fir_tvalid = tvalid_q;
  assign coeff_wr_en       = wr_q;
  assign coeff_addr        = addr_q;
  assign coeff_data        = cdata_q;
  assign load_done         = done_q;
  assign overrun           = ovr_q;
endmodule
